// File: rtl/vote_controller.sv
// Vote sequencer: resolves debounced vote pulses, keeps saturating tallies, enforces a lockout
// window and drives the result display. Define VOTE_TOTAL_EN to add a saturating total-vote count.
module vote_controller #(
    parameter int          NUM_CAND    = 4,
    parameter int          CNT_W       = 8,
    parameter int unsigned LOCK_CYCLES = 100000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_mode,
    input  logic [NUM_CAND-1:0] i_valid_vote,
    input  logic [NUM_CAND-1:0] i_sel,
    output logic                o_vote_ack,
    output logic                o_vote_reject,
    output logic                o_busy,
`ifdef VOTE_TOTAL_EN
    output logic [CNT_W+1:0]    o_total_votes,
`endif
    output logic [CNT_W-1:0]    o_led
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCK,
        S_RESULT
    } state_t;

    localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [31:0]         r_lock_cnt;
    logic [CNT_W-1:0]    r_count [NUM_CAND];
    logic [NUM_CAND-1:0] r_last_cand;
    logic                r_vote_ack;
    logic                r_vote_reject;
    logic                r_busy;
    logic [CNT_W-1:0]    r_led;
`ifdef VOTE_TOTAL_EN
    logic [CNT_W+1:0]    r_total;
`endif

    logic                w_multi;
    logic                w_one_hot;
    logic                w_accept;
    logic                w_reject;
    logic                w_lock_done;
    logic                w_next_busy;
    logic [NUM_CAND-1:0] w_next_last;
    logic [CNT_W-1:0]    w_result_val;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign w_multi     = (i_valid_vote & (i_valid_vote - NUM_CAND'(1))) != '0;
    assign w_one_hot   = (i_valid_vote != '0) && !w_multi;
    assign w_next_busy = w_accept | (r_busy & ~w_lock_done);
    assign w_next_last = w_accept ? i_valid_vote : r_last_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_lock_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_mode) begin
                    w_next_state = S_RESULT;
                end else if (w_one_hot) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LOCK;
                end else if (w_multi) begin
                    w_reject = 1'b1;
                end
            end
            S_LOCK: begin
                if (r_lock_cnt == LOCK_LAST) begin
                    w_lock_done  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_RESULT: begin
                if (!i_mode) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Lowest-index selected candidate wins; walking downwards lets it overwrite the others.
    always_comb begin
`ifdef VOTE_TOTAL_EN
        w_result_val = r_total[CNT_W-1:0];
`else
        w_result_val = '0;
`endif
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (i_sel[i]) begin
                w_result_val = r_count[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt    <= '0;
            r_last_cand   <= '0;
            r_vote_ack    <= 1'b0;
            r_vote_reject <= 1'b0;
            r_busy        <= 1'b0;
            r_led         <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            r_vote_ack    <= w_accept;
            r_vote_reject <= w_reject;
            r_busy        <= w_next_busy;
            r_last_cand   <= w_next_last;
            if (w_accept) begin
                r_lock_cnt <= '0;
            end else if (r_state == S_LOCK) begin
                r_lock_cnt <= r_lock_cnt + 32'd1;
            end
            for (int i = 0; i < NUM_CAND; i++) begin
                if (w_accept && i_valid_vote[i] && (r_count[i] != '1)) begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end
            end
            // Last-candidate display follows the new busy value so both change on the same edge.
            if (r_state == S_RESULT) begin
                r_led <= w_result_val;
            end else if (w_next_busy) begin
                r_led <= CNT_W'(w_next_last);
            end else begin
                r_led <= '0;
            end
        end
    end

`ifdef VOTE_TOTAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (w_accept && (r_total != '1)) begin
            r_total <= r_total + (CNT_W+2)'(1);
        end
    end

    assign o_total_votes = r_total;
`endif

    assign o_vote_ack    = r_vote_ack;
    assign o_vote_reject = r_vote_reject;
    assign o_busy        = r_busy;
    assign o_led         = r_led;

endmodule
